div_result_bcd_display: RTL
===========================

Name: div_result_bcd_display

Overview:
- Downstream consumer of the 7-bit sequential divider.
- Captures cociente/residuo on the divider's done pulse and converts both to 3-digit BCD with a sequential shift-add-3 (double-dabble) engine.
- Drives a 4-digit multiplexed seven-segment display showing either quotient or remainder.
- Digit 3 shows a 'q'/'r' tag; digits 2..0 show the value with leading-zero blanking.

Parameters:
- REFRESH_DIV, 27000: clk cycles each digit stays lit; legal range is ≥2; counter width is $clog2(REFRESH_DIV).
- SEG_ACTIVE_LOW, 1: 1 = seg and an outputs are active-low; 0 = active-high.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- res_valid  in  1  result-valid pulse; connects to divider done.
- cociente  in  7  quotient; must be stable whenever res_valid=1.
- residuo  in  7  remainder; must be stable whenever res_valid=1.
- sel_resid  in  1  0 = display quotient, 1 = display remainder; synchronous to clk.
- busy_conv  out  1  conversion in progress.
- bcd_valid  out  1  one-cycle pulse when new BCD results are loaded.
- bcd_q  out  12  quotient BCD {hundreds,tens,units}.
- bcd_r  out  12  remainder BCD {hundreds,tens,units}.
- an  out  4  digit enables, one-hot (polarity per SEG_ACTIVE_LOW).
- seg  out  7  segments {g,f,e,d,c,b,a} (polarity per SEG_ACTIVE_LOW).

Behaviour:
- Reset values (defaults, SEG_ACTIVE_LOW=1):
  - busy_conv=0, bcd_valid=0, bcd_q=0, bcd_r=0.
  - Digit index=0, refresh counter=0, FSM=IDLE.
  - an=4'b1110, seg=7'b1000000 (units digit shows '0').
- FSM states: IDLE, CONV_Q, CONV_R, UPDATE.
  - IDLE -> CONV_Q on a rising edge with res_valid=1 (edge E0). At E0: latch cociente/residuo into shift registers, clear the BCD working regs, load the iteration counter with 7.
  - CONV_Q: one iteration per edge. For each working nibble ≥5, add 3; then shift left by one, bringing in the next quotient bit, MSB (bit 6) first. Counter decrements each iteration.
  - CONV_Q -> CONV_R at E7, after 7 iterations. The counter reloads to 7; the next 7 iterations (E8..E14) operate identically on the remainder.
  - CONV_R -> UPDATE at E14.
  - UPDATE -> IDLE at E15. At E15: bcd_q and bcd_r load from the working regs, and bcd_valid is set.
  - bcd_valid clears at E16. It is registered and high for exactly one cycle.
- Latency: res_valid sampled at E0 -> new bcd_q/bcd_r and bcd_valid=1 visible after E15.
- busy_conv = (state != IDLE): high after E0, low after E15.
- res_valid while busy_conv=1 is ignored, with no queuing. res_valid at E15 (state UPDATE) is also ignored; res_valid at E16 is accepted.
- bcd_q/bcd_r hold the previous result until E15. A partial conversion is never visible on the outputs.
- Width rules:
  - Working BCD is 12 bits.
  - Max input 127 -> 0x127. Hundreds digit is ≤1; no overflow is possible.
  - Add-3 is applied per nibble before the shift, on all three nibbles.
- Display scan:
  - The refresh counter counts 0..REFRESH_DIV-1. On wrap it returns to 0 and the digit index advances 0->1->2->3->0.
  - The scan runs continuously and independently of the FSM.
  - an enables digit[index] only.
- Digit content:
  - Digit 3: 'q' if sel_resid=0, 'r' if sel_resid=1.
  - Digits 2..0: hundreds/tens/units of bcd_q (sel_resid=0) or bcd_r (sel_resid=1).
  - Blanking: hundreds is blank if 0; tens is blank if hundreds=0 and tens=0; units is always shown.
- Segment encoding (active-high, before polarity is applied):
  - '0'=3F, '1'=06, '2'=5B, '3'=4F, '4'=66, '5'=6D, '6'=7D, '7'=07, '8'=7F, '9'=6F.
  - 'q'=67, 'r'=50, blank=00. Nibble values >9 display blank.
- seg/an derivation: combinational from index, sel_resid and the bcd registers.
- sel_resid change: takes effect on the currently lit digit in the same cycle.
- Reset mid-operation: asserting rst_n low at any time forces all reset values immediately.
  - Any in-flight conversion is discarded, and no bcd_valid is produced.

Test Plan:
- Reset -> busy_conv=0, bcd_valid=0, bcd_q=bcd_r=0x000, an=1110, seg=1000000.
- res_valid pulse with cociente=14, residuo=2 (100/7) -> busy_conv high E0..E15; bcd_q=0x014, bcd_r=0x002, bcd_valid=1 only in the cycle after E15.
- cociente=127, residuo=0 -> bcd_q=0x127, bcd_r=0x000. Then cociente=0, residuo=99 -> bcd_q=0x000, bcd_r=0x099.
- Extra res_valid pulses at E3 and E15 with different operands -> ignored, first result unchanged. A pulse at E16 starts a new conversion.
- REFRESH_DIV=4, bcd_q=0x014, sel_resid=0 -> an cycles 1110,1101,1011,0111 every 4 clocks. seg active-low: '4'=0011001, '1'=1111001, blank=1111111, 'q'=0011000. Switching sel_resid=1 with bcd_r=0x002 shows '2','blank','blank','r'.
- rst_n low at E8 (mid CONV_R) -> all outputs return to reset values immediately; no bcd_valid after release. A fresh res_valid converts correctly.

Source files
------------

// File: rtl/div_result_bcd_display.sv
// Result display for the 7-bit sequential divider: captures quotient/remainder on done,
// converts both to 3-digit BCD with a sequential double-dabble, and scans a 4-digit 7-seg display.
module div_result_bcd_display #(
    parameter int REFRESH_DIV    = 27000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        res_valid,
    input  logic [6:0]  cociente,
    input  logic [6:0]  residuo,
    input  logic        sel_resid,
    output logic        busy_conv,
    output logic        bcd_valid,
    output logic [11:0] bcd_q,
    output logic [11:0] bcd_r,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV_Q = 2'd1,
        CONV_R = 2'd2,
        UPDATE = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [2:0]    iter_r;
    logic [6:0]    sh_q_r;
    logic [6:0]    sh_r_r;
    logic [11:0]   work_q_r;
    logic [11:0]   work_r_r;
    logic [11:0]   step_q_s;
    logic [11:0]   step_r_s;
    logic          busy_r;
    logic          bcd_valid_r;
    logic [11:0]   bcd_q_r;
    logic [11:0]   bcd_r_r;
    logic [RW-1:0] ref_cnt_r;
    logic [1:0]    digit_r;
    logic [11:0]   shown_s;
    logic [6:0]    seg_raw_s;
    logic [3:0]    an_raw_s;

    // One double-dabble iteration: add 3 to every nibble >= 5, then shift in the next bit.
    function automatic logic [11:0] dabble_step(input logic [11:0] w, input logic b);
        logic [11:0] t;
        t = w;
        for (int i = 0; i < 3; i++) begin
            if (t[i*4 +: 4] >= 4'd5) begin
                t[i*4 +: 4] = t[i*4 +: 4] + 4'd3;
            end else begin
                t[i*4 +: 4] = t[i*4 +: 4];
            end
        end
        return {t[10:0], b};
    endfunction

    // Active-high segment pattern {g,f,e,d,c,b,a} for a decimal nibble; non-decimal is blank.
    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; each conversion phase ends when the last iteration is taken.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (res_valid) state_s = CONV_Q;
                else           state_s = IDLE;
            end
            CONV_Q: begin
                if (iter_r == 3'd1) state_s = CONV_R;
                else                state_s = CONV_Q;
            end
            CONV_R: begin
                if (iter_r == 3'd1) state_s = UPDATE;
                else                state_s = CONV_R;
            end
            UPDATE:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    assign step_q_s = dabble_step(work_q_r, sh_q_r[6]);
    assign step_r_s = dabble_step(work_r_r, sh_r_r[6]);

    // Conversion datapath; published results only change in UPDATE so partial values stay hidden.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter_r      <= 3'd0;
            sh_q_r      <= 7'd0;
            sh_r_r      <= 7'd0;
            work_q_r    <= 12'd0;
            work_r_r    <= 12'd0;
            bcd_valid_r <= 1'b0;
            bcd_q_r     <= 12'd0;
            bcd_r_r     <= 12'd0;
            busy_r      <= 1'b0;
        end else begin
            bcd_valid_r <= 1'b0;
            busy_r      <= (state_s != IDLE);
            case (state_r)
                IDLE: begin
                    if (res_valid) begin
                        sh_q_r   <= cociente;
                        sh_r_r   <= residuo;
                        work_q_r <= 12'd0;
                        work_r_r <= 12'd0;
                        iter_r   <= 3'd7;
                    end
                end
                CONV_Q: begin
                    work_q_r <= step_q_s;
                    sh_q_r   <= {sh_q_r[5:0], 1'b0};
                    iter_r   <= (iter_r == 3'd1) ? 3'd7 : (iter_r - 3'd1);
                end
                CONV_R: begin
                    work_r_r <= step_r_s;
                    sh_r_r   <= {sh_r_r[5:0], 1'b0};
                    iter_r   <= iter_r - 3'd1;
                end
                UPDATE: begin
                    bcd_q_r     <= work_q_r;
                    bcd_r_r     <= work_r_r;
                    bcd_valid_r <= 1'b1;
                end
                default: begin
                    bcd_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Free-running refresh counter and digit index, independent of the conversion FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt_r <= '0;
            digit_r   <= 2'd0;
        end else if (ref_cnt_r == REF_LAST) begin
            ref_cnt_r <= '0;
            digit_r   <= digit_r + 2'd1;
        end else begin
            ref_cnt_r <= ref_cnt_r + RW'(1);
            digit_r   <= digit_r;
        end
    end

    // Digit content with leading-zero blanking; combinational so sel_resid acts immediately.
    always_comb begin
        shown_s   = sel_resid ? bcd_r_r : bcd_q_r;
        seg_raw_s = 7'h00;
        an_raw_s  = 4'b0001 << digit_r;
        case (digit_r)
            2'd3: begin
                if (sel_resid) seg_raw_s = 7'h50;
                else           seg_raw_s = 7'h67;
            end
            2'd2: begin
                if (shown_s[11:8] == 4'd0) seg_raw_s = 7'h00;
                else                       seg_raw_s = seg_digit(shown_s[11:8]);
            end
            2'd1: begin
                if ((shown_s[11:8] == 4'd0) && (shown_s[7:4] == 4'd0)) seg_raw_s = 7'h00;
                else                                                   seg_raw_s = seg_digit(shown_s[7:4]);
            end
            2'd0:    seg_raw_s = seg_digit(shown_s[3:0]);
            default: seg_raw_s = 7'h00;
        endcase
    end

    assign busy_conv = busy_r;
    assign bcd_valid = bcd_valid_r;
    assign bcd_q     = bcd_q_r;
    assign bcd_r     = bcd_r_r;
    assign seg       = SEG_ACTIVE_LOW ? ~seg_raw_s : seg_raw_s;
    assign an        = SEG_ACTIVE_LOW ? ~an_raw_s  : an_raw_s;

endmodule
